// File: rtl/l1b_arb_pkg.sv
// Shared types and constants for the L1Buffer read-request arbiter.
// Address width comes from the L1B_ADDR_WIDTH macro, defaulting to 8.
`ifndef L1B_ADDR_WIDTH
`define L1B_ADDR_WIDTH 8
`endif

package l1b_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  localparam int MIN_SPACING = 4;

  localparam logic SRC_R3 = 1'b0;
  localparam logic SRC_L1 = 1'b1;

  localparam int L1B_ADDR_W = `L1B_ADDR_WIDTH;

endpackage

// File: rtl/l1b_req_fifo.sv
// Per-source request queue: DEPTH-entry FIFO using wrap-bit pointers, with a
// sticky overflow flag raised whenever a request has to be dropped.
module l1b_req_fifo #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] din,
  input  logic              pop,
  output logic [ADDR_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  logic [PW:0]       wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] mem [DEPTH];
  logic              do_push, do_pop;

  // Handshake: pop is honoured only while !empty; push is accepted when
  // !full or when a pop happens on the same edge, otherwise it is dropped.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/l1b_read_request_arbiter.sv
// Arbitrates queued R3 and L1 read requests into spaced AI/BI pulses for the
// L1Buffer read-address selector. L1B_ARB_ROUNDROBIN_EN enables fair contested arbitration.
module l1b_read_request_arbiter
  import l1b_arb_pkg::*;
#(
  parameter int ADDR_W  = L1B_ADDR_W,
  parameter int DEPTH   = 4,
  parameter int SPACING = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              R3Trig,
  input  logic [ADDR_W-1:0] R3Addr,
  input  logic              L1Trig,
  input  logic [ADDR_W-1:0] L1Addr,
  output logic              AI,
  output logic              BI,
  output logic [ADDR_W-1:0] AddressIn1,
  output logic [ADDR_W-1:0] AddressIn2,
  output logic              R3Full,
  output logic              L1Full,
  output logic              R3Overflow,
  output logic              L1Overflow,
  output logic              Busy,
  output arb_state_e        dbg_state
);
  localparam int CW = $clog2(SPACING + 1);

  if (SPACING < MIN_SPACING) begin : g_bad_spacing
    $error("SPACING must be at least MIN_SPACING");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two, at least 2");
  end

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              r3_empty, l1_empty;
  logic [ADDR_W-1:0] r3_head, l1_head;
  logic              pop_r3, pop_l1, issue, win, contested_win;

  l1b_req_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_r3_fifo (
    .clk(CLK), .rst(RST), .push(R3Trig), .din(R3Addr), .pop(pop_r3),
    .dout(r3_head), .empty(r3_empty), .full(R3Full), .overflow(R3Overflow)
  );

  l1b_req_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_l1_fifo (
    .clk(CLK), .rst(RST), .push(L1Trig), .din(L1Addr), .pop(pop_l1),
    .dout(l1_head), .empty(l1_empty), .full(L1Full), .overflow(L1Overflow)
  );

`ifdef L1B_ARB_ROUNDROBIN_EN
  // Points at the source that wins the next contested arbitration.
  logic prio_l1;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                   prio_l1 <= 1'b0;
    else if (issue && !r3_empty && !l1_empty)  prio_l1 <= (win == SRC_R3);
  end
  assign contested_win = prio_l1 ? SRC_L1 : SRC_R3;
`else
  assign contested_win = SRC_R3;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    win     = SRC_R3;
    pop_r3  = 1'b0;
    pop_l1  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!r3_empty || !l1_empty) begin
          issue   = 1'b1;
          win     = (!r3_empty && !l1_empty) ? contested_win : (r3_empty ? SRC_L1 : SRC_R3);
          pop_r3  = (win == SRC_R3);
          pop_l1  = (win == SRC_L1);
          state_d = ST_HOLD;
          cnt_d   = CW'(SPACING - 1);
        end
      end
      ST_HOLD: begin
        // Leaving at count 1 places the next issue exactly SPACING edges after this one.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      AI         <= 1'b0;
      BI         <= 1'b0;
      AddressIn1 <= '0;
      AddressIn2 <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      AI      <= pop_r3;
      BI      <= pop_l1;
      if (pop_r3) AddressIn1 <= r3_head;
      if (pop_l1) AddressIn2 <= l1_head;
    end
  end

  assign Busy      = (state_q != ST_IDLE) || !r3_empty || !l1_empty;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_l1b_read_request_arbiter.sv
// Self-checking bench for l1b_read_request_arbiter: a queue-based reference
// model predicts every AI/BI pulse, and a negedge monitor compares outputs.
module tb_l1b_read_request_arbiter;
  import l1b_arb_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 4;
  localparam int SPACING = 4;
  localparam int EW      = 16 + 1 + ADDR_W;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              R3Trig = 1'b0, L1Trig = 1'b0;
  logic [ADDR_W-1:0] R3Addr = '0, L1Addr = '0;
  logic              AI, BI, R3Full, L1Full, R3Overflow, L1Overflow, Busy;
  logic [ADDR_W-1:0] AddressIn1, AddressIn2;
  arb_state_e        dbg_state;

  l1b_read_request_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SPACING(SPACING)) dut (
    .CLK(CLK), .RST(RST), .R3Trig(R3Trig), .R3Addr(R3Addr), .L1Trig(L1Trig), .L1Addr(L1Addr),
    .AI(AI), .BI(BI), .AddressIn1(AddressIn1), .AddressIn2(AddressIn2),
    .R3Full(R3Full), .L1Full(L1Full), .R3Overflow(R3Overflow), .L1Overflow(L1Overflow),
    .Busy(Busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  int tests_run = 0;
  int tests_failed = 0;

  logic [EW-1:0]     exp_q[$];
  logic [ADDR_W-1:0] m_r3[$];
  logic [ADDR_W-1:0] m_l1[$];
  logic [ADDR_W:0]   pulse_log[$];
  logic [ADDR_W-1:0] m_addr1 = '0, m_addr2 = '0;
  logic              m_ovf1 = 1'b0, m_ovf2 = 1'b0, m_prio_l1 = 1'b0;
  int                cyc = 0;
  int                m_last = -1000;
  int                last_pulse = -1000;
  int                ai_count = 0, bi_count = 0;
  logic              mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic model_busy();
    return (m_r3.size() != 0) || (m_l1.size() != 0) || ((cyc + 1 - m_last) < SPACING);
  endfunction

  // Reference model: issue decided from pre-edge queue contents, then pushes.
  task automatic run_model();
    logic              win_l1;
    logic [ADDR_W-1:0] a;
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        m_r3.delete();
        m_l1.delete();
        m_last    = -1000;
        m_addr1   = '0;
        m_addr2   = '0;
        m_ovf1    = 1'b0;
        m_ovf2    = 1'b0;
        m_prio_l1 = 1'b0;
      end else begin
        cyc++;
        if ((cyc - m_last) >= SPACING && (m_r3.size() != 0 || m_l1.size() != 0)) begin
          if (m_r3.size() != 0 && m_l1.size() != 0) begin
`ifdef L1B_ARB_ROUNDROBIN_EN
            win_l1    = m_prio_l1;
            m_prio_l1 = !win_l1;
`else
            win_l1 = 1'b0;
`endif
          end else begin
            win_l1 = (m_r3.size() == 0);
          end
          if (win_l1) begin
            a = m_l1.pop_front();
            m_addr2 = a;
          end else begin
            a = m_r3.pop_front();
            m_addr1 = a;
          end
          exp_q.push_back({cyc[15:0], win_l1, a});
          m_last = cyc;
        end
        if (R3Trig) begin
          if (m_r3.size() < DEPTH) m_r3.push_back(R3Addr);
          else m_ovf1 = 1'b1;
        end
        if (L1Trig) begin
          if (m_l1.size() < DEPTH) m_l1.push_back(L1Addr);
          else m_ovf2 = 1'b1;
        end
      end
    end
  endtask

  // Output monitor, sampled on the falling edge.
  task automatic run_monitor();
    logic [EW-1:0] e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        exp_q.delete();
      end else if (mon_en) begin
        check_eq("ai_bi_excl", 32'(AI & BI), 32'(0));
        if (AI || BI) begin
          if (BI) bi_count++;
          else    ai_count++;
          pulse_log.push_back({BI, BI ? AddressIn2 : AddressIn1});
          check_eq("pulse_spacing", 32'((cyc - last_pulse) >= SPACING), 32'(1));
          last_pulse = cyc;
          if (exp_q.size() == 0) begin
            check_eq("pulse_expected", 32'(exp_q.size()), 32'(1));
          end else begin
            e = exp_q.pop_front();
            check_eq("pulse_edge_src_addr", 32'({cyc[15:0], BI, BI ? AddressIn2 : AddressIn1}), 32'(e));
          end
        end else if (exp_q.size() != 0) begin
          check_eq("missing_pulse", 32'(exp_q.size()), 32'(0));
          exp_q.delete();
        end
        check_eq("addr1_stable", 32'(AddressIn1), 32'(m_addr1));
        check_eq("addr2_stable", 32'(AddressIn2), 32'(m_addr2));
        check_eq("r3_full", 32'(R3Full), 32'(m_r3.size() == DEPTH));
        check_eq("l1_full", 32'(L1Full), 32'(m_l1.size() == DEPTH));
        check_eq("r3_overflow", 32'(R3Overflow), 32'(m_ovf1));
        check_eq("l1_overflow", 32'(L1Overflow), 32'(m_ovf2));
        check_eq("busy", 32'(Busy), 32'(model_busy()));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_cycle(input logic r3t, input logic [ADDR_W-1:0] r3a,
                            input logic l1t, input logic [ADDR_W-1:0] l1a);
    R3Trig = r3t;
    R3Addr = r3a;
    L1Trig = l1t;
    L1Addr = l1a;
    @(negedge CLK);
    R3Trig = 1'b0;
    L1Trig = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (!model_busy() && exp_q.size() == 0 && !Busy) break;
      @(negedge CLK);
    end
    repeat (2) @(negedge CLK);
    check_eq("drain_busy", 32'(Busy), 32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ai"}, 32'(AI), 32'(0));
    check_eq({tag, "_bi"}, 32'(BI), 32'(0));
    check_eq({tag, "_addr1"}, 32'(AddressIn1), 32'(0));
    check_eq({tag, "_addr2"}, 32'(AddressIn2), 32'(0));
    check_eq({tag, "_flags"}, 32'({R3Full, L1Full, R3Overflow, L1Overflow, Busy}), 32'(0));
    check_eq({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a0, b0;
    logic [ADDR_W:0] exp_first, exp_second;
    fork
      run_model();
      run_monitor();
      begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    #3;
    check_all_zero("reset");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge CLK);

    // Single R3 request on an idle system.
    R3Trig = 1'b1;
    R3Addr = 8'h2A;
    @(negedge CLK);
    R3Trig = 1'b0;
    check_eq("t1_ai_not_yet", 32'(AI), 32'(0));
    @(negedge CLK);
    check_eq("t1_ai", 32'(AI), 32'(1));
    check_eq("t1_addr1", 32'(AddressIn1), 32'(8'h2A));
    check_eq("t1_bi", 32'(BI), 32'(0));
    repeat (2) @(negedge CLK);
    check_eq("t1_busy_hold", 32'(Busy), 32'(1));
    @(negedge CLK);
    check_eq("t1_busy_done", 32'(Busy), 32'(0));
    wait_drain();

    // Contested requests, twice.
    pulse_log.delete();
    push_cycle(1'b1, 8'h10, 1'b1, 8'h20);
    wait_drain();
    push_cycle(1'b1, 8'h11, 1'b1, 8'h21);
    wait_drain();
    check_eq("t2_count", 32'(pulse_log.size()), 32'(4));
    if (pulse_log.size() == 4) begin
      check_eq("t2_first", 32'(pulse_log[0]), 32'({1'b0, 8'h10}));
      check_eq("t2_second", 32'(pulse_log[1]), 32'({1'b1, 8'h20}));
`ifdef L1B_ARB_ROUNDROBIN_EN
      exp_first  = {1'b1, 8'h21};
      exp_second = {1'b0, 8'h11};
`else
      exp_first  = {1'b0, 8'h11};
      exp_second = {1'b1, 8'h21};
`endif
      check_eq("t2_third", 32'(pulse_log[2]), 32'(exp_first));
      check_eq("t2_fourth", 32'(pulse_log[3]), 32'(exp_second));
    end

    // Five back-to-back R3 pushes: fills the queue, no drop.
    pulse_log.delete();
    for (int i = 0; i < 5; i++) push_cycle(1'b1, 8'(8'h31 + i), 1'b0, '0);
    check_eq("t3_full", 32'(R3Full), 32'(1));
    check_eq("t3_no_ovf", 32'(R3Overflow), 32'(0));
    wait_drain();
    check_eq("t3_count", 32'(pulse_log.size()), 32'(5));
    for (int i = 0; i < 5 && i < pulse_log.size(); i++)
      check_eq("t3_order", 32'(pulse_log[i]), 32'({1'b0, 8'(8'h31 + i)}));

    // L1 overflow while the arbiter is held by an R3 issue.
    b0 = bi_count;
    pulse_log.delete();
    push_cycle(1'b1, 8'h40, 1'b0, '0);
    for (int i = 0; i < 6; i++) push_cycle(1'b0, '0, 1'b1, 8'(8'h50 + i));
    check_eq("t4_ovf", 32'(L1Overflow), 32'(1));
    wait_drain();
    check_eq("t4_bi_count", 32'(bi_count - b0), 32'(5));
    check_eq("t4_ovf_sticky", 32'(L1Overflow), 32'(1));
    for (int i = 1; i < 6 && i < pulse_log.size(); i++)
      check_eq("t4_order", 32'(pulse_log[i]), 32'({1'b1, 8'(8'h50 + i - 1)}));

    // Asynchronous reset during HOLD with two queued R3 entries.
    for (int i = 0; i < 3; i++) push_cycle(1'b1, 8'(8'h61 + i), 1'b0, '0);
    check_eq("t5_in_hold", 32'(dbg_state), 32'(ST_HOLD));
    check_eq("t5_queued", 32'(Busy), 32'(1));
    #2;
    RST = 1'b1;
    #1;
    check_all_zero("t5_async");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    a0 = ai_count;
    repeat (8) @(negedge CLK);
    check_eq("t5_no_ai", 32'(ai_count - a0), 32'(0));
    push_cycle(1'b1, 8'h70, 1'b0, '0);
    wait_drain();
    check_eq("t5_new_ai", 32'(ai_count - a0), 32'(1));
    check_eq("t5_addr1", 32'(AddressIn1), 32'(8'h70));

    // Alternating R3/L1 pushes with random addresses.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) push_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, '0);
      else            push_cycle(1'b0, '0, 1'b1, 8'($urandom_range(0, 255)));
    end
    wait_drain();
    check_eq("final_exp_empty", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
